// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter (sync header, MSB-first payload, optional even parity, idle gap)
module seq_frame_tx #(
  parameter int DATA_W = 8,
  parameter int SYNC_W = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
  parameter bit PARITY_EN = 1'b1,
  parameter int GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              dout,
  output logic              dout_en,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy
);
  localparam int CMAX = (SYNC_W > DATA_W) ? ((SYNC_W > 16) ? SYNC_W : 16) : ((DATA_W > 16) ? DATA_W : 16);
  localparam int CW = $clog2(CMAX);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PAR, GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, data_sh;
  logic [SYNC_W-1:0] sync_sh;
  logic par_q, par_d;
  logic dout_q, dout_d, en_q, en_d, start_q, start_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      dout_q  <= 1'b0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    case (state_q)
      IDLE: if (valid_in && ready_q) begin
        state_d = SYNC;
        cnt_d   = '0;
        sh_d    = data_in;
        par_d   = ^data_in;
      end
      SYNC: begin
        state_d = (cnt_q == CW'(SYNC_W - 1)) ? DATA : SYNC;
        cnt_d   = (cnt_q == CW'(SYNC_W - 1)) ? '0 : cnt_q + CW'(1);
      end
      DATA: begin
        state_d = (cnt_q != CW'(DATA_W - 1)) ? DATA : PARITY_EN ? PAR : (GAP_BITS > 0) ? GAP : IDLE;
        cnt_d   = (cnt_q == CW'(DATA_W - 1)) ? '0 : cnt_q + CW'(1);
      end
      PAR: begin
        state_d = (GAP_BITS > 0) ? GAP : IDLE;
        cnt_d   = '0;
      end
      GAP: begin
        state_d = (cnt_q == CW'(GAP_BITS - 1)) ? IDLE : GAP;
        cnt_d   = (cnt_q == CW'(GAP_BITS - 1)) ? '0 : cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so they can be registered without adding a cycle of latency.
  always_comb begin
    sync_sh = SYNC_PAT << cnt_d;
    data_sh = sh_d << cnt_d;
    dout_d  = (state_d == SYNC) ? sync_sh[SYNC_W-1] : (state_d == DATA) ? data_sh[DATA_W-1] : (state_d == PAR) ? par_d : 1'b0;
    en_d    = (state_d == SYNC) || (state_d == DATA) || (state_d == PAR);
    start_d = (state_q == IDLE) && (state_d == SYNC);
    done_d  = (state_d == PAR) || (!PARITY_EN && (state_d == DATA) && (cnt_d == CW'(DATA_W - 1)));
    busy_d  = state_d != IDLE;
    ready_d = state_d == IDLE;
  end
  assign dout        = dout_q;
  assign dout_en     = en_q;
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign busy        = busy_q;
  assign ready_out   = ready_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: directed bench for seq_frame_tx, one DUT with parity and one without
module tb_seq_frame_tx;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic v0 = 1'b0, v1 = 1'b0;
  logic r0, o0, e0, s0, f0, b0;
  logic r1, o1, e1, s1, f1, b1;
  int tests = 0;
  int fails = 0;
  int hits = 0;
  logic [3:0] det = 4'b0;

  seq_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_EN(1'b1), .GAP_BITS(2)) dut0 (
    .clk(clk), .rstn(rstn), .data_in(d0), .valid_in(v0), .ready_out(r0),
    .dout(o0), .dout_en(e0), .frame_start(s0), .frame_done(f0), .busy(b0));
  seq_frame_tx #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b1011), .PARITY_EN(1'b0), .GAP_BITS(2)) dut1 (
    .clk(clk), .rstn(rstn), .data_in(d1), .valid_in(v1), .ready_out(r1),
    .dout(o1), .dout_en(e1), .frame_start(s1), .frame_done(f1), .busy(b1));

  always #5 clk = ~clk;

  // Downstream overlapping 1011 detector watching dut0's line
  always @(negedge clk) begin
    det <= {det[2:0], o0};
    if ({det[2:0], o0} == 4'b1011) hits <= hits + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input bit which, input logic [7:0] w, output logic [15:0] dv, output logic [15:0] ev,
                         output logic [15:0] sv, output logic [15:0] fv, output logic [15:0] rv);
    int t = 0;
    dv = '0; ev = '0; sv = '0; fv = '0; rv = '0;
    while ((which ? r1 : r0) !== 1'b1 && t < 64) begin
      tick();
      t++;
    end
    tests++;
    if (t == 64) begin
      fails++;
      $display("FAIL ready_wait: got ready=0 after %0d cycles want ready=1", t);
    end
    if (which) begin d1 = w; v1 = 1'b1; end else begin d0 = w; v0 = 1'b1; end
    tick();
    v0 = 1'b0;
    v1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dv = {dv[14:0], which ? o1 : o0};
      ev = {ev[14:0], which ? e1 : e0};
      sv = {sv[14:0], which ? s1 : s0};
      fv = {fv[14:0], which ? f1 : f0};
      rv = {rv[14:0], which ? r1 : r0};
      tick();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({r0, o0, e0, s0, f0, b0, r1, o1, e1, s1, f1, b1} !== 12'b0) begin
        fails++;
        $display("FAIL reset_outputs: got %b want %b", {r0, o0, e0, s0, f0, b0, r1, o1, e1, s1, f1, b1}, 12'b0);
      end
    end
    rstn = 1'b1;
    tick();
    tests++;
    if ({r0, r1} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready: got %b want 11", {r0, r1});
    end
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if ({r0, o0, e0, b0, s0} !== 5'b10000) begin
      fails++;
      $display("FAIL idle_quiet: got %b want 10000", {r0, o0, e0, b0, s0});
    end
  endtask

  task automatic test_single();
    logic [15:0] dv, ev, sv, fv, rv;
    int h = hits;
    capture(1'b0, 8'hA5, dv, ev, sv, fv, rv);
    tests++;
    if (dv !== {13'b1011_10100101_0, 3'b0}) begin fails++; $display("FAIL single_dout: got %b want %b", dv, {13'b1011_10100101_0, 3'b0}); end
    tests++;
    if (ev !== 16'hFFF8) begin fails++; $display("FAIL single_en: got %h want fff8", ev); end
    tests++;
    if (sv !== 16'h8000) begin fails++; $display("FAIL single_start: got %h want 8000", sv); end
    tests++;
    if (fv !== 16'h0008) begin fails++; $display("FAIL single_done: got %h want 0008", fv); end
    tests++;
    if (rv !== 16'h0001) begin fails++; $display("FAIL single_ready: got %h want 0001", rv); end
    tests++;
    if (hits - h !== 1) begin fails++; $display("FAIL single_detect: got %0d hits want 1", hits - h); end
  endtask

  task automatic test_parity();
    logic [15:0] dv, ev, sv, fv, rv;
    capture(1'b0, 8'h07, dv, ev, sv, fv, rv);
    tests++;
    if (dv !== {13'b1011_00000111_1, 3'b0}) begin fails++; $display("FAIL parity_dout: got %b want %b", dv, {13'b1011_00000111_1, 3'b0}); end
    capture(1'b1, 8'h07, dv, ev, sv, fv, rv);
    tests++;
    if (dv !== {12'b1011_00000111, 4'b0}) begin fails++; $display("FAIL nopar_dout: got %b want %b", dv, {12'b1011_00000111, 4'b0}); end
    tests++;
    if (ev !== 16'hFFF0) begin fails++; $display("FAIL nopar_en: got %h want fff0", ev); end
    tests++;
    if (fv !== 16'h0010) begin fails++; $display("FAIL nopar_done: got %h want 0010", fv); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] dv = '0, sv = '0, rv = '0;
    tests++;
    if (r0 !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1", r0); end
    d0 = 8'hFF;
    v0 = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      dv = {dv[30:0], o0};
      sv = {sv[30:0], s0};
      rv = {rv[30:0], r0};
      if (i == 0) d0 = 8'h00;
      if (i == 16) v0 = 1'b0;
      tick();
    end
    tests++;
    if (sv !== 32'h8000_8000) begin fails++; $display("FAIL b2b_start: got %h want 80008000", sv); end
    tests++;
    if (dv !== {13'b1011_11111111_0, 3'b0, 13'b1011_00000000_0, 3'b0}) begin
      fails++;
      $display("FAIL b2b_dout: got %b want %b", dv, {13'b1011_11111111_0, 3'b0, 13'b1011_00000000_0, 3'b0});
    end
    tests++;
    if (rv !== 32'h0001_0001) begin fails++; $display("FAIL b2b_readyseq: got %h want 00010001", rv); end
  endtask

  task automatic test_ignored();
    logic [15:0] dv = '0, sv = '0, rv = '0;
    d0 = 8'h3C;
    v0 = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      dv = {dv[14:0], o0};
      sv = {sv[14:0], s0};
      rv = {rv[14:0], r0};
      d0 = ~d0 ^ 8'(i);
      v0 = (i < 13) ? ~v0 : 1'b0;
      tick();
    end
    tests++;
    if (dv !== {13'b1011_00111100_0, 3'b0}) begin fails++; $display("FAIL ignored_dout: got %b want %b", dv, {13'b1011_00111100_0, 3'b0}); end
    tests++;
    if ({sv, rv} !== {16'h8000, 16'h0001}) begin fails++; $display("FAIL ignored_accept: got %h want 80000001", {sv, rv}); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] dv = '0, ev, sv, fv = '0, rv;
    d0 = 8'h5A;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      dv = {dv[14:0], o0};
      fv = {fv[14:0], f0};
      if (i < 8) tick();
    end
    rstn = 1'b0;
    tick();
    tests++;
    if ({o0, e0, b0, r0, f0} !== 5'b0) begin fails++; $display("FAIL midrst_outputs: got %b want 00000", {o0, e0, b0, r0, f0}); end
    rstn = 1'b1;
    tick();
    tests++;
    if ({r0, f0, b0} !== 3'b100) begin fails++; $display("FAIL midrst_release: got %b want 100", {r0, f0, b0}); end
    tests++;
    if ({dv[8:0], fv[8:0]} !== {9'b1011_01011, 9'b0}) begin fails++; $display("FAIL midrst_partial: got %b want %b", {dv[8:0], fv[8:0]}, {9'b1011_01011, 9'b0}); end
    capture(1'b0, 8'h81, dv, ev, sv, fv, rv);
    tests++;
    if ({dv, fv} !== {13'b1011_10000001_0, 3'b0, 16'h0008}) begin
      fails++;
      $display("FAIL midrst_next: got %b want %b", {dv, fv}, {13'b1011_10000001_0, 3'b0, 16'h0008});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_ignored();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
